// File: rtl/rr_arbiter_4.sv
// -----------------------------------------------------------------------------
// rr_arbiter_4
//   Round-robin arbiter that shares one resource among four requesters.
//   A grant is registered and one-hot. Every grant is followed by exactly one
//   idle cycle before the next grant is issued. A hold limit forces the owner
//   to release, so one requester cannot starve the others.
//
// Parameters
//   HOLD_MAX  maximum number of consecutive cycles a grant may be held (0 = no limit)
//   CNT_W     hold-counter width; 2**CNT_W must exceed HOLD_MAX
//
// Ports
//   clk      in   1  rising-edge clock
//   rst_n    in   1  synchronous active-low reset
//   req      in   4  level-sensitive request vector, bit i = requester i
//   rel      in   1  owner release pulse, only looked at while granting
//   gnt      out  4  registered one-hot grant, 4'b0000 when idle
//   gnt_id   out  2  index of the granted requester, 0 when gnt_vld = 0
//   gnt_vld  out  1  high while a grant is active (== |gnt)
//   ptr      out  2  round-robin priority pointer, for visibility
// -----------------------------------------------------------------------------
module rr_arbiter_4 #(
    parameter int HOLD_MAX = 16,
    parameter int CNT_W    = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic       rel,
    output logic [3:0] gnt,
    output logic [1:0] gnt_id,
    output logic       gnt_vld,
    output logic [1:0] ptr
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t           state_q;
    logic [3:0]       gnt_q;
    logic [1:0]       gnt_id_q;
    logic             gnt_vld_q;
    logic [1:0]       ptr_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    logic       pick_vld;
    logic [1:0] pick_id;
    logic [1:0] idx;
    logic       hold_done;
    logic       release_now;

    // Rotating priority search. Offsets are scanned from the highest down to
    // the lowest, so the last match wins and that match is the requester
    // nearest to ptr in the order ptr, ptr+1, ... (mod 4).
    always_comb begin
        pick_vld = 1'b0;
        pick_id  = 2'd0;
        idx      = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            idx = ptr_q + 2'(k);
            if (req[idx]) begin
                pick_vld = 1'b1;
                pick_id  = idx;
            end
        end
    end

    // cnt_q counts the grant cycles already completed. The grant is released
    // at the end of its HOLD_MAX-th cycle, so it lasts exactly HOLD_MAX cycles.
    assign hold_done   = (HOLD_MAX != 0) && (cnt_q == CNT_W'(HOLD_MAX - 1));
    assign release_now = !req[gnt_id_q] || rel || hold_done;
    assign cnt_d       = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            gnt_q     <= 4'b0000;
            gnt_id_q  <= 2'd0;
            gnt_vld_q <= 1'b0;
            ptr_q     <= 2'd0;
            cnt_q     <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (pick_vld) begin
                        state_q   <= S_GRANT;
                        gnt_q     <= 4'b0001 << pick_id;
                        gnt_id_q  <= pick_id;
                        gnt_vld_q <= 1'b1;
                        cnt_q     <= '0;
                    end
                end
                S_GRANT: begin
                    if (release_now) begin
                        // Moving the pointer past the owner keeps the rotation
                        // fair. A sole requester is still found again when the
                        // search wraps around.
                        state_q   <= S_IDLE;
                        gnt_q     <= 4'b0000;
                        gnt_id_q  <= 2'd0;
                        gnt_vld_q <= 1'b0;
                        ptr_q     <= gnt_id_q + 2'd1;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                default: begin
                    state_q   <= S_IDLE;
                    gnt_q     <= 4'b0000;
                    gnt_id_q  <= 2'd0;
                    gnt_vld_q <= 1'b0;
                end
            endcase
        end
    end

    assign gnt     = gnt_q;
    assign gnt_id  = gnt_id_q;
    assign gnt_vld = gnt_vld_q;
    assign ptr     = ptr_q;

endmodule

// File: tb/tb_rr_arbiter_4.sv
module tb_rr_arbiter_4;

    localparam int HOLD_MAX = 4;
    localparam int CNT_W    = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic       rel;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       gnt_vld;
    logic [1:0] ptr;

    rr_arbiter_4 #(
        .HOLD_MAX(HOLD_MAX),
        .CNT_W   (CNT_W)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req),
        .rel    (rel),
        .gnt    (gnt),
        .gnt_id (gnt_id),
        .gnt_vld(gnt_vld),
        .ptr    (ptr)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct packed {
        logic [3:0] gnt;
        logic [1:0] id;
        logic       vld;
        logic [1:0] ptr;
    } exp_t;

    exp_t sb_q[$];

    // Reference model state
    logic       m_vld = 1'b0;
    logic [1:0] m_id  = 2'd0;
    logic [1:0] m_ptr = 2'd0;
    int         m_cnt = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input logic rn, input logic [3:0] r, input logic rl);
        int  sel;
        bit  found;
        if (!rn) begin
            m_vld = 1'b0; m_id = 2'd0; m_ptr = 2'd0; m_cnt = 0;
        end else if (!m_vld) begin
            found = 1'b0;
            sel   = 0;
            for (int k = 0; k < 4; k++) begin
                int i;
                i = (int'(m_ptr) + k) % 4;
                if (!found && r[i]) begin
                    found = 1'b1;
                    sel   = i;
                end
            end
            if (found) begin
                m_vld = 1'b1; m_id = 2'(sel); m_cnt = 0;
            end
        end else begin
            if (!r[m_id] || rl || (HOLD_MAX != 0 && m_cnt == HOLD_MAX - 1)) begin
                m_ptr = 2'((int'(m_id) + 1) % 4);
                m_vld = 1'b0;
                m_id  = 2'd0;
            end else if (m_cnt < (1 << CNT_W) - 1) begin
                m_cnt++;
            end
        end
    endtask

    // Drive one cycle of stimulus, predict the post-edge outputs, then compare.
    task automatic step(input logic rn, input logic [3:0] r, input logic rl, input string tag);
        exp_t e;
        rst_n = rn;
        req   = r;
        rel   = rl;
        model_step(rn, r, rl);
        e.gnt = m_vld ? (4'b0001 << m_id) : 4'b0000;
        e.id  = m_id;
        e.vld = m_vld;
        e.ptr = m_ptr;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            check_eq({tag, ".sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            check_eq({tag, ".gnt"},     32'(gnt),     32'(e.gnt));
            check_eq({tag, ".gnt_id"},  32'(gnt_id),  32'(e.id));
            check_eq({tag, ".gnt_vld"}, 32'(gnt_vld), 32'(e.vld));
            check_eq({tag, ".ptr"},     32'(ptr),     32'(e.ptr));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0] rot_ids [5];
        logic [3:0] to_seq  [11];
        logic [3:0] to_exp  [11];
        logic [3:0] r;
        logic       rn;
        logic       rl;

        to_exp = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000,
                   4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b0001};

        // Reset with all requests asserted
        step(1'b0, 4'hF, 1'b0, "rst0");
        step(1'b0, 4'hF, 1'b0, "rst1");
        check_eq("rst.gnt", 32'(gnt), 32'h0);
        check_eq("rst.ptr", 32'(ptr), 32'h0);
        step(1'b1, 4'hF, 1'b0, "rst_exit");
        check_eq("rst_exit.gnt", 32'(gnt), 32'h1);

        // Rotation: a release pulse one cycle into each grant
        rot_ids[0] = gnt_id;
        for (int g = 1; g < 5; g++) begin
            step(1'b1, 4'hF, 1'b1, "rot_rel");
            check_eq("rot_idle", 32'(gnt), 32'h0);
            step(1'b1, 4'hF, 1'b0, "rot_gnt");
            rot_ids[g] = gnt_id;
        end
        for (int g = 0; g < 5; g++) begin
            check_eq($sformatf("rot_id%0d", g), 32'(rot_ids[g]), 32'(g % 4));
        end
        step(1'b1, 4'hF, 1'b1, "rot_end");

        // Single requester
        step(1'b1, 4'b0100, 1'b0, "single_gnt");
        check_eq("single.gnt",    32'(gnt),    32'h4);
        check_eq("single.gnt_id", 32'(gnt_id), 32'd2);
        step(1'b1, 4'b0000, 1'b0, "single_drop");
        check_eq("single.drop_gnt", 32'(gnt), 32'h0);
        check_eq("single.ptr",      32'(ptr), 32'd3);

        // Forced release after HOLD_MAX cycles
        for (int c = 0; c < 11; c++) begin
            step(1'b1, 4'b0011, 1'b0, "timeout");
            to_seq[c] = gnt;
        end
        for (int c = 0; c < 11; c++) begin
            check_eq($sformatf("timeout_seq%0d", c), 32'(to_seq[c]), 32'(to_exp[c]));
        end

        // Wrap-around search: 2, 3, 0
        step(1'b0, 4'b0000, 1'b0, "wrap_rst");
        step(1'b1, 4'b1000, 1'b0, "wrap_g3");
        step(1'b1, 4'b0000, 1'b0, "wrap_i3");
        check_eq("wrap.ptr0", 32'(ptr), 32'd0);
        step(1'b1, 4'b0010, 1'b0, "wrap_g1");
        step(1'b1, 4'b0000, 1'b0, "wrap_i1");
        check_eq("wrap.ptr2", 32'(ptr), 32'd2);
        step(1'b1, 4'b0001, 1'b0, "wrap_g0");
        check_eq("wrap.gnt", 32'(gnt), 32'h1);

        // Reset in the middle of a grant
        step(1'b1, 4'b0000, 1'b0, "mid_idle");
        step(1'b1, 4'b1000, 1'b0, "mid_g3");
        check_eq("mid.gnt3", 32'(gnt), 32'h8);
        step(1'b0, 4'b1001, 1'b0, "mid_rst");
        check_eq("mid.rst_gnt", 32'(gnt),    32'h0);
        check_eq("mid.rst_id",  32'(gnt_id), 32'd0);
        check_eq("mid.rst_ptr", 32'(ptr),    32'd0);
        step(1'b1, 4'b1001, 1'b0, "mid_after");
        check_eq("mid.after_gnt", 32'(gnt), 32'h1);

        // Random traffic, with occasional resets and requests held stable
        r = 4'hF;
        for (int c = 0; c < 200; c++) begin
            rn = ($urandom_range(0, 39) != 0);
            if ($urandom_range(0, 2) == 0) r = 4'($urandom_range(0, 15));
            rl = ($urandom_range(0, 4) == 0);
            step(rn, r, rl, "rand");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
